load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Responder end of the scheduler→LSU request interface. Accepts one load or store per handshake from the scheduling front, using the AGU-computed address and the store data.
- Performs the access over an 8-bit little-endian memory bus: one beat for byte accesses, two beats for word accesses.
- Returns load results on the tagged write-back channel (data, tag, wb strobe) consumed by the reservation stations.
- Exerts back-pressure on the scheduler through lsu_wait.

Parameters:
- RDY_TIMEOUT, 255: max cycles a bus beat waits for mem_rdy before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- a_rst  in  1  reset, synchronous, active-low
- lsu_rq_start  in  1  request valid
- lsu_rq_cmd  in  1  1 = store, 0 = load
- lsu_rq_width  in  1  1 = 16-bit word, 0 = byte
- lsu_rq_tag  in  1  issuing station (0 = rsa, 1 = rsb)
- agu_adr  in  16  effective address
- st_data  in  16  store data
- lsu_wait  out  1  busy; request not accepted
- lsu_data_out  out  16  load result
- lsu_data_tag  out  2  {1'b0, captured tag}
- lsu_data_wb  out  1  load result valid, one-cycle pulse
- lsu_fault  out  1  timeout abort, one-cycle pulse
- mem_adr  out  16  bus address
- mem_rd  out  1  read strobe
- mem_wr  out  1  write strobe
- mem_dout  out  8  write data
- mem_din  in  8  read data
- mem_rdy  in  1  beat complete when sampled high with a strobe

Behaviour:
- States: IDLE, LO, HI. lsu_wait = (state != IDLE), decoded combinationally from the registered state.
- Acceptance: in IDLE, lsu_rq_start=1 latches cmd, width, tag, agu_adr and st_data; next state LO. A request while lsu_wait=1 is ignored; the scheduler holds it.
- LO:
  - mem_adr = adr.
  - mem_rd = ~cmd, mem_wr = cmd.
  - mem_dout = data[7:0].
  - On mem_rdy: a load captures mem_din into result[7:0]. Next state is HI if width=1, else IDLE.
- HI:
  - mem_adr = adr+1, modulo 2^16 (0xFFFF → 0x0000).
  - mem_dout = data[15:8].
  - On mem_rdy: a load captures result[15:8]. Next state IDLE.
- Strobes and address are held stable until mem_rdy is sampled. Strobes are 0 in IDLE; mem_adr and mem_dout are don't-care there.
- Write-back:
  - The cycle after a load's final beat: lsu_data_wb=1 for exactly one cycle.
  - lsu_data_out = result; byte loads are zero-extended (result[15:8] = 0).
  - lsu_data_tag = {1'b0, tag}.
  - Stores produce no write-back.
- Back-to-back: in the IDLE cycle carrying the wb pulse, lsu_wait=0 and a new request is accepted.
- Latency with mem_rdy tied high:
  - Byte load: accept at cycle 0, beat at cycle 1, wb at cycle 2.
  - Word load: wb at cycle 3.
  - Store: lsu_wait high 1 cycle (byte) or 2 cycles (word).
- Timeout:
  - Per-beat counter cleared on entry to LO and on the LO→HI transition; increments each cycle without mem_rdy.
  - When the count reaches RDY_TIMEOUT (RDY_TIMEOUT≠0): go to IDLE, pulse lsu_fault next cycle, no wb. A partially written word store is not rolled back.
- Reset (a_rst=0 at a clock edge, including mid-access): state IDLE, counter 0, result 0, lsu_wait=0, lsu_data_wb=0, lsu_fault=0, mem_rd=mem_wr=0, lsu_data_out=0, lsu_data_tag=0. No write-back is produced for the aborted access.

Optional Feature:
- LSU_PAGE_WRAP_EN defined: the HI beat address is {adr[15:8], adr[7:0]+1}, so the page does not carry (6502 page-wrap semantics). Word at 0x12FF reads 0x12FF then 0x1200.
- Undefined: full 16-bit increment. Word at 0x12FF reads 0x12FF then 0x1300.

Test Plan:
- Byte load, adr=0x0040, tag=1, mem_din=0xA5, mem_rdy=1 → mem_rd asserted at cycle 1 with mem_adr=0x0040; at cycle 2 wb=1, data=0x00A5, tag=2'b01.
- Word store, adr=0xFFFF, st_data=0xBEEF, mem_rdy=1 → writes 0xEF@0xFFFF then 0xBE@0x0000; lsu_wait high 2 cycles; no wb.
- Word load, mem_rdy low 3 cycles on each beat, din 0x34 then 0x12 → wb once with data=0x1234; lsu_wait high 8 cycles.
- Back-to-back: second byte load held by the scheduler arrives in the wb cycle of the first → accepted immediately; its beat starts next cycle.
- RDY_TIMEOUT=4, mem_rdy stuck low → abort after 4 cycles, lsu_fault pulses, no wb, next request accepted.
- a_rst low during the HI beat of a word load → strobes drop next edge, no wb, all outputs at reset values.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: takes one scheduler request at a time and runs it as 1-2 byte beats on an 8-bit
// little-endian memory bus. Optional macro LSU_PAGE_WRAP_EN keeps the word HI beat inside the LO page.
module load_store_unit #(
   parameter int unsigned RDY_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        a_rst,
   input  logic        lsu_rq_start,
   input  logic        lsu_rq_cmd,
   input  logic        lsu_rq_width,
   input  logic        lsu_rq_tag,
   input  logic [15:0] agu_adr,
   input  logic [15:0] st_data,
   output logic        lsu_wait,
   output logic [15:0] lsu_data_out,
   output logic [1:0]  lsu_data_tag,
   output logic        lsu_data_wb,
   output logic        lsu_fault,
   output logic [15:0] mem_adr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [7:0]  mem_dout,
   input  logic [7:0]  mem_din,
   input  logic        mem_rdy
);
   localparam int unsigned CNT_W = (RDY_TIMEOUT < 2) ? 1 : $clog2(RDY_TIMEOUT + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               cmd_q, cmd_d;
   logic               width_q, width_d;
   logic               tag_q, tag_d;
   logic [15:0]        adr_q, adr_d;
   logic [15:0]        data_q, data_d;
   logic [15:0]        result_q, result_d;
   logic               wb_q, wb_d;
   logic               fault_q, fault_d;
   logic [15:0]        adr_hi_c;
   logic               timeout_c;

`ifdef LSU_PAGE_WRAP_EN
   assign adr_hi_c = {adr_q[15:8], adr_q[7:0] + 8'd1};
`else
   assign adr_hi_c = adr_q + 16'd1;
`endif

   // A stalled beat gives up in the cycle its wait count would reach RDY_TIMEOUT.
   assign timeout_c = (RDY_TIMEOUT != 0) && !mem_rdy &&
                      (cnt_q == CNT_W'(RDY_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!a_rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         cmd_q    <= 1'b0;
         width_q  <= 1'b0;
         tag_q    <= 1'b0;
         adr_q    <= '0;
         data_q   <= '0;
         result_q <= '0;
         wb_q     <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cmd_q    <= cmd_d;
         width_q  <= width_d;
         tag_q    <= tag_d;
         adr_q    <= adr_d;
         data_q   <= data_d;
         result_q <= result_d;
         wb_q     <= wb_d;
         fault_q  <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (lsu_rq_start) begin
               state_d = ST_LO;
               cnt_d   = '0;
            end
         end
         ST_LO: begin
            if (mem_rdy) begin
               state_d = width_q ? ST_HI : ST_IDLE;
               cnt_d   = '0;
            end else if (timeout_c) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HI: begin
            if (mem_rdy) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (timeout_c) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      cmd_d    = cmd_q;
      width_d  = width_q;
      tag_d    = tag_q;
      adr_d    = adr_q;
      data_d   = data_q;
      result_d = result_q;
      wb_d     = 1'b0;
      fault_d  = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      mem_adr  = adr_q;
      mem_dout = data_q[7:0];
      case (state_q)
         ST_IDLE: begin
            if (lsu_rq_start) begin
               cmd_d   = lsu_rq_cmd;
               width_d = lsu_rq_width;
               tag_d   = lsu_rq_tag;
               adr_d   = agu_adr;
               data_d  = st_data;
            end
         end
         ST_LO: begin
            mem_rd = ~cmd_q;
            mem_wr = cmd_q;
            if (mem_rdy) begin
               // Upper byte cleared here so byte loads come out zero-extended.
               if (!cmd_q) result_d = {8'h00, mem_din};
               wb_d = !cmd_q && !width_q;
            end else if (timeout_c) begin
               fault_d = 1'b1;
            end
         end
         ST_HI: begin
            mem_rd   = ~cmd_q;
            mem_wr   = cmd_q;
            mem_adr  = adr_hi_c;
            mem_dout = data_q[15:8];
            if (mem_rdy) begin
               if (!cmd_q) result_d[15:8] = mem_din;
               wb_d = !cmd_q;
            end else if (timeout_c) begin
               fault_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign lsu_wait     = (state_q != ST_IDLE);
   assign lsu_data_out = result_q;
   assign lsu_data_tag = {1'b0, tag_q};
   assign lsu_data_wb  = wb_q;
   assign lsu_fault    = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a byte-array memory plus a per-request reference model of
// expected bus beats, write-back and fault behaviour.
module tb_load_store_unit;
   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        a_rst;
   logic        lsu_rq_start, lsu_rq_cmd, lsu_rq_width, lsu_rq_tag;
   logic [15:0] agu_adr, st_data;
   logic        lsu_wait;
   logic [15:0] lsu_data_out;
   logic [1:0]  lsu_data_tag;
   logic        lsu_data_wb, lsu_fault;
   logic [15:0] mem_adr;
   logic        mem_rd, mem_wr;
   logic [7:0]  mem_dout, mem_din;
   logic        mem_rdy;

   always #5 clk = ~clk;

   load_store_unit #(.RDY_TIMEOUT(TO)) dut (
      .clk(clk), .a_rst(a_rst),
      .lsu_rq_start(lsu_rq_start), .lsu_rq_cmd(lsu_rq_cmd), .lsu_rq_width(lsu_rq_width),
      .lsu_rq_tag(lsu_rq_tag), .agu_adr(agu_adr), .st_data(st_data),
      .lsu_wait(lsu_wait), .lsu_data_out(lsu_data_out), .lsu_data_tag(lsu_data_tag),
      .lsu_data_wb(lsu_data_wb), .lsu_fault(lsu_fault),
      .mem_adr(mem_adr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout),
      .mem_din(mem_din), .mem_rdy(mem_rdy)
   );

   logic [7:0]  bus_mem [65536];
   logic [7:0]  ref_mem [65536];
   int          n_chk = 0;
   int          n_fail = 0;
   logic        pend_wb = 1'b0, pend_fault = 1'b0, pend_rst = 1'b0;
   logic [15:0] pend_data = '0;
   logic [1:0]  pend_tag = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] hi_adr(input logic [15:0] a);
`ifdef LSU_PAGE_WRAP_EN
      return {a[15:8], 8'(a[7:0] + 8'd1)};
`else
      return 16'(a + 16'd1);
`endif
   endfunction

   // Called on a falling edge when the unit should be idle; settles last request's outcome.
   task automatic check_idle();
      check_eq("idle_wait", 32'(lsu_wait), 32'd0);
      check_eq("idle_strobes", 32'({mem_rd, mem_wr}), 32'd0);
      check_eq("wb_pulse", 32'(lsu_data_wb), 32'(pend_wb));
      check_eq("fault_pulse", 32'(lsu_fault), 32'(pend_fault));
      if (pend_wb) begin
         check_eq("wb_data", 32'(lsu_data_out), 32'(pend_data));
         check_eq("wb_tag", 32'(lsu_data_tag), 32'(pend_tag));
      end
      if (pend_rst) begin
         check_eq("rst_data", 32'(lsu_data_out), 32'd0);
         check_eq("rst_tag", 32'(lsu_data_tag), 32'd0);
      end
      pend_wb = 1'b0; pend_fault = 1'b0; pend_rst = 1'b0;
      a_rst = 1'b1;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      check_idle();
      lsu_rq_start = 1'b0;
      mem_rdy = 1'($urandom);
      @(posedge clk);
   endtask

   // One request; a stall >= TO means that beat times out. rst_hi resets in the HI beat.
   task automatic do_req(input logic cmd, input logic width, input logic tag, input logic [15:0] adr,
                         input logic [15:0] data, input int st0, input int st1, input bit rst_hi);
      logic [15:0] res;
      logic [15:0] a;
      logic [7:0]  exp_byte;
      int          stall;
      res = '0;
      @(negedge clk);
      check_idle();
      lsu_rq_start = 1'b1; lsu_rq_cmd = cmd; lsu_rq_width = width; lsu_rq_tag = tag;
      agu_adr = adr; st_data = data; mem_rdy = 1'($urandom);
      @(posedge clk);
      for (int b = 0; b < (width ? 2 : 1); b++) begin
         a        = (b == 1) ? hi_adr(adr) : adr;
         exp_byte = (b == 1) ? data[15:8] : data[7:0];
         stall    = (b == 1) ? st1 : st0;
         for (int c = 0; c <= stall; c++) begin
            @(negedge clk);
            // Requests while busy must be ignored.
            lsu_rq_start = 1'($urandom); lsu_rq_cmd = 1'($urandom); lsu_rq_width = 1'($urandom);
            lsu_rq_tag = 1'($urandom); agu_adr = 16'($urandom); st_data = 16'($urandom);
            check_eq("busy_wait", 32'(lsu_wait), 32'd1);
            check_eq("mem_adr", 32'(mem_adr), 32'(a));
            check_eq("mem_rd", 32'(mem_rd), 32'(!cmd));
            check_eq("mem_wr", 32'(mem_wr), 32'(cmd));
            if (cmd) check_eq("mem_dout", 32'(mem_dout), 32'(exp_byte));
            if (rst_hi && b == 1) begin
               a_rst = 1'b0; mem_rdy = 1'b1; mem_din = 8'($urandom);
               @(posedge clk);
               pend_rst = 1'b1;
               return;
            end
            if (c < stall) begin
               mem_rdy = 1'b0; mem_din = 8'($urandom);
               @(posedge clk);
               if (stall >= int'(TO) && c == int'(TO) - 1) begin
                  pend_fault = 1'b1;
                  return;
               end
            end else begin
               mem_rdy = 1'b1;
               mem_din = bus_mem[a];
               if (cmd) begin
                  bus_mem[a] = mem_dout;
                  ref_mem[a] = exp_byte;
                  check_eq("mem_store", 32'(bus_mem[a]), 32'(ref_mem[a]));
               end else begin
                  res[b*8 +: 8] = ref_mem[a];
               end
               @(posedge clk);
            end
         end
      end
      pend_wb   = !cmd;
      pend_data = res;
      pend_tag  = {1'b0, tag};
   endtask

   initial begin
      logic        r_cmd, r_w, r_tag;
      logic [15:0] r_adr, r_dat;
      int          r_st0, r_st1;
      for (int i = 0; i < 65536; i++) begin
         bus_mem[i] = 8'($urandom);
         ref_mem[i] = bus_mem[i];
      end
      a_rst = 1'b0; lsu_rq_start = 1'b0; lsu_rq_cmd = 1'b0; lsu_rq_width = 1'b0; lsu_rq_tag = 1'b0;
      agu_adr = '0; st_data = '0; mem_din = '0; mem_rdy = 1'b0;
      repeat (2) @(posedge clk);
      pend_rst = 1'b1;

      bus_mem[16'h0040] = 8'hA5; ref_mem[16'h0040] = 8'hA5;
      do_req(1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000, 0, 0, 1'b0);
      do_req(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hBEEF, 0, 0, 1'b0);
      bus_mem[16'h3000] = 8'h34; ref_mem[16'h3000] = 8'h34;
      bus_mem[16'h3001] = 8'h12; ref_mem[16'h3001] = 8'h12;
      do_req(1'b0, 1'b1, 1'b1, 16'h3000, 16'h0000, 3, 3, 1'b0);
      do_req(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 0, 0, 1'b0);
      do_req(1'b0, 1'b1, 1'b0, 16'h12FF, 16'h0000, 1, 2, 1'b0);
      do_req(1'b0, 1'b0, 1'b1, 16'h1000, 16'h0000, TO, 0, 1'b0);
      do_req(1'b1, 1'b1, 1'b1, 16'h2000, 16'hCAFE, 0, TO, 1'b0);
      do_req(1'b0, 1'b1, 1'b0, 16'h2000, 16'h0000, 0, 0, 1'b0);
      do_req(1'b0, 1'b1, 1'b1, 16'h4000, 16'h0000, 0, 1, 1'b1);
      idle_cycle();

      for (int i = 0; i < 300; i++) begin
         r_cmd = 1'($urandom); r_w = 1'($urandom); r_tag = 1'($urandom);
         r_adr = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         r_dat = 16'($urandom);
         r_st0 = ($urandom_range(0, 19) == 0) ? int'(TO) : int'($urandom_range(0, 3));
         r_st1 = ($urandom_range(0, 19) == 0) ? int'(TO) : int'($urandom_range(0, 3));
         repeat ($urandom_range(0, 2)) idle_cycle();
         do_req(r_cmd, r_w, r_tag, r_adr, r_dat, r_st0, r_st1, ($urandom_range(0, 29) == 0));
      end
      idle_cycle();
      idle_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
